// File: rtl/axi_rd_responder_pkg.sv
// Shared AXI encodings and the read-responder state type.
package axi_rd_responder_pkg;

  typedef logic [2:0] axi_burst_size;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10,
    AXI_BURST_RSVD  = 2'b11
  } axi_burst_type;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_response;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_resp_state_e;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst address stepper and burst legality check.
// next_addr is the address of the beat after addr; legal judges the burst
// as if addr were its start address.
module axi_burst_addr_gen
  import axi_rd_responder_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              legal
);

  localparam logic [2:0] BUS_SIZE = 3'($clog2(DATA_W / 8));

  axi_burst_type     burst_t;
  logic [ADDR_W-1:0] bytes;
  logic [ADDR_W-1:0] total;
  logic [ADDR_W-1:0] lower;
  logic [ADDR_W-1:0] wrap_next;

  assign burst_t = axi_burst_type'(burst);

  // Step to the next beat address according to the burst type.
  always_comb begin
    bytes     = ADDR_W'(1) << size;
    total     = bytes * ADDR_W'({1'b0, len} + 9'd1);
    lower     = addr & ~(total - ADDR_W'(1));
    wrap_next = addr + bytes;
    next_addr = addr;
    case (burst_t)
      AXI_BURST_INCR: next_addr = (addr & ~(bytes - ADDR_W'(1))) + bytes;
      AXI_BURST_WRAP: next_addr = (wrap_next == lower + total) ? lower : wrap_next;
      default:        next_addr = addr;
    endcase
  end

  // Flag bursts the responder refuses as a whole.
  always_comb begin
    legal = 1'b1;
    if (burst_t == AXI_BURST_RSVD) legal = 1'b0;
    if (size > BUS_SIZE) legal = 1'b0;
    if (burst_t == AXI_BURST_WRAP) begin
      if (!wrap_len_ok(len)) legal = 1'b0;
      if ((addr & (bytes - ADDR_W'(1))) != '0) legal = 1'b0;
    end
  end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read-channel responder backed by an internal word memory.
// Accepts one AR at a time and streams registered R beats with per-beat RRESP.
module axi_rd_responder
  import axi_rd_responder_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                ID_W      = 4,
  parameter int                MEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         arvalid_i,
  output logic                         arready_o,
  input  logic [ID_W-1:0]              arid_i,
  input  logic [ADDR_W-1:0]            araddr_i,
  input  logic [7:0]                   arlen_i,
  input  logic [2:0]                   arsize_i,
  input  logic [1:0]                   arburst_i,
  output logic                         rvalid_o,
  input  logic                         rready_i,
  output logic [ID_W-1:0]              rid_o,
  output logic [DATA_W-1:0]            rdata_o,
  output logic [1:0]                   rresp_o,
  output logic                         rlast_o,
  input  logic                         mem_we_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr_i,
  input  logic [DATA_W-1:0]            mem_wdata_i
);

  localparam int              MEM_AW    = $clog2(MEM_DEPTH);
  localparam int              BYTE_LOG2 = $clog2(DATA_W / 8);
  localparam logic [ADDR_W:0] SPAN      = (ADDR_W + 1)'(MEM_DEPTH * (DATA_W / 8));

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  rd_resp_state_e    state_q, state_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  axi_response       rresp_q, rresp_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  axi_burst_size     size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [8:0]        beat_q, beat_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] gen_addr;
  logic [7:0]        gen_len;
  logic [2:0]        gen_size;
  logic [1:0]        gen_burst;
  logic [ADDR_W-1:0] gen_next;
  logic              gen_legal;

  logic [ADDR_W-1:0] beat_addr;
  logic              beat_err;
  logic [ADDR_W:0]   beat_off;
  logic              beat_in_range;
  logic [MEM_AW-1:0] beat_idx;
  logic [DATA_W-1:0] beat_data;
  axi_response       beat_resp;

  // While idle the generator judges the incoming AR; during a burst it steps the latched address.
  assign gen_addr  = (state_q == IDLE) ? araddr_i  : addr_q;
  assign gen_len   = (state_q == IDLE) ? arlen_i   : len_q;
  assign gen_size  = (state_q == IDLE) ? arsize_i  : size_q;
  assign gen_burst = (state_q == IDLE) ? arburst_i : burst_q;

  axi_burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_addr_gen (
    .addr      (gen_addr),
    .len       (gen_len),
    .size      (gen_size),
    .burst     (gen_burst),
    .next_addr (gen_next),
    .legal     (gen_legal)
  );

  // Preload port; memory contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_i) mem[mem_waddr_i] <= mem_wdata_i;
  end

  // Pick the address and burst-error flag of whichever beat would be loaded this cycle.
  always_comb begin
    beat_addr = (state_q == IDLE) ? araddr_i : gen_next;
    beat_err  = (state_q == IDLE) ? !gen_legal : err_q;
  end

  // Decode the candidate beat into data and response.
  always_comb begin
    beat_off      = {1'b0, beat_addr} - {1'b0, BASE_ADDR};
    beat_in_range = !beat_off[ADDR_W] && (beat_off < SPAN);
    beat_idx      = MEM_AW'(beat_off[ADDR_W-1:0] >> BYTE_LOG2);
    beat_data     = '0;
    beat_resp     = AXI_RESP_OKAY;
    if (beat_err) begin
      beat_resp = AXI_RESP_SLVERR;
    end else if (!beat_in_range) begin
      beat_resp = AXI_RESP_DECERR;
    end else begin
      beat_data = mem[beat_idx];
    end
  end

  // Next-state and next-output logic for the AR/R handshakes.
  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (arvalid_i && arready_q) begin
          addr_d    = araddr_i;
          len_d     = arlen_i;
          size_d    = arsize_i;
          burst_d   = arburst_i;
          err_d     = !gen_legal;
          beat_d    = 9'd0;
          rid_d     = arid_i;
          rdata_d   = beat_data;
          rresp_d   = beat_resp;
          rlast_d   = (arlen_i == 8'd0);
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          state_d   = BURST;
        end
      end
      BURST: begin
        if (rvalid_q && rready_i) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            state_d   = IDLE;
          end else begin
            addr_d  = gen_next;
            beat_d  = beat_q + 9'd1;
            rdata_d = beat_data;
            rresp_d = beat_resp;
            rlast_d = ((beat_q + 9'd1) == {1'b0, len_q});
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= AXI_RESP_OKAY;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
    end
  end

  assign arready_o = arready_q;
  assign rvalid_o  = rvalid_q;
  assign rlast_o   = rlast_q;
  assign rid_o     = rid_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;

endmodule

// File: tb/tb_axi_rd_responder.sv
// Bench for axi_rd_responder: directed vector table, hand-written corner
// sequences, and randomized bursts checked against a burst-level model.
module tb_axi_rd_responder;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int ID_W      = 4;
  localparam int MEM_DEPTH = 256;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              arvalid_i = 1'b0;
  logic              arready_o;
  logic [ID_W-1:0]   arid_i = '0;
  logic [ADDR_W-1:0] araddr_i = '0;
  logic [7:0]        arlen_i = '0;
  logic [2:0]        arsize_i = '0;
  logic [1:0]        arburst_i = '0;
  logic              rvalid_o;
  logic              rready_i = 1'b0;
  logic [ID_W-1:0]   rid_o;
  logic [DATA_W-1:0] rdata_o;
  logic [1:0]        rresp_o;
  logic              rlast_o;
  logic              mem_we_i = 1'b0;
  logic [7:0]        mem_waddr_i = '0;
  logic [DATA_W-1:0] mem_wdata_i = '0;

  always #5 clk_i = ~clk_i;

  axi_rd_responder #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .ID_W      (ID_W),
    .MEM_DEPTH (MEM_DEPTH),
    .BASE_ADDR ('0)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .arvalid_i   (arvalid_i),
    .arready_o   (arready_o),
    .arid_i      (arid_i),
    .araddr_i    (araddr_i),
    .arlen_i     (arlen_i),
    .arsize_i    (arsize_i),
    .arburst_i   (arburst_i),
    .rvalid_o    (rvalid_o),
    .rready_i    (rready_i),
    .rid_o       (rid_o),
    .rdata_o     (rdata_o),
    .rresp_o     (rresp_o),
    .rlast_o     (rlast_o),
    .mem_we_i    (mem_we_i),
    .mem_waddr_i (mem_waddr_i),
    .mem_wdata_i (mem_wdata_i)
  );

  int n_compared = 0;
  int n_mismatch = 0;
  logic [31:0] mem_model [MEM_DEPTH];

  typedef struct {
    string            name;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       id;
    logic [3:0][31:0] exp_data;
    logic [3:0][1:0]  exp_resp;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: burst legality from the AXI rules.
  function automatic logic model_legal(input logic [31:0] start, input int len, input int size, input int burst);
    longint bytes = longint'(1) << size;
    longint s = {32'd0, start};
    if (burst == 3) return 1'b0;
    if (bytes > 4) return 1'b0;
    if (burst == 2) begin
      if (!(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b0;
      if (s % bytes != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference model: address of beat i computed directly from the burst geometry.
  function automatic logic [31:0] model_addr(input logic [31:0] start, input int len, input int size, input int burst, input int i);
    longint bytes = longint'(1) << size;
    longint total = bytes * (len + 1);
    longint s = {32'd0, start};
    longint lower;
    if (burst == 0) return start;
    if (burst == 2) begin
      lower = (s / total) * total;
      return 32'(lower + ((s - lower + i * bytes) % total));
    end
    if (i == 0) return start;
    return 32'((s / bytes) * bytes + i * bytes);
  endfunction

  task automatic model_beat(input logic [31:0] start, input int len, input int size, input int burst,
                            input int i, output logic [31:0] data, output logic [1:0] resp);
    logic [31:0] a;
    a = model_addr(start, len, size, burst, i);
    if (!model_legal(start, len, size, burst)) begin
      resp = 2'b10; data = '0;
    end else if (a < 32'h400) begin
      resp = 2'b00; data = mem_model[a / 4];
    end else begin
      resp = 2'b11; data = '0;
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    mem_we_i = 1'b1; mem_waddr_i = 8'(idx); mem_wdata_i = data;
    @(negedge clk_i);
    mem_we_i = 1'b0;
    mem_model[idx] = data;
  endtask

  task automatic setVec(input int k, input string name, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3,
                        input logic [1:0] r0, input logic [1:0] r1, input logic [1:0] r2, input logic [1:0] r3);
    vecs[k].name = name; vecs[k].addr = addr; vecs[k].len = len; vecs[k].size = size;
    vecs[k].burst = burst; vecs[k].id = id;
    vecs[k].exp_data = {d3, d2, d1, d0};
    vecs[k].exp_resp = {r3, r2, r1, r0};
  endtask

  // Drives an AR from the current negedge; returns at the negedge after the handshake edge.
  task automatic issueAr(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, input logic rr, input string name);
    int wait_cnt;
    arvalid_i = 1'b1; araddr_i = addr; arlen_i = len; arsize_i = size; arburst_i = burst; arid_i = id;
    rready_i = rr;
    wait_cnt = 0;
    while (!arready_o && wait_cnt < 20) begin
      @(negedge clk_i);
      wait_cnt++;
    end
    checkOutput({name, " ar accepted"}, 64'(arready_o), 64'd1);
    @(negedge clk_i);
    arvalid_i = 1'b0;
    checkOutput({name, " first rvalid"}, 64'(rvalid_o), 64'd1);
    checkOutput({name, " arready low in burst"}, 64'(arready_o), 64'd0);
  endtask

  // Runs one table vector with rready held high and checks every beat back to back.
  task automatic applyStimulus(input vec_t v);
    issueAr(v.addr, v.len, v.size, v.burst, v.id, 1'b1, v.name);
    for (int b = 0; b <= int'(v.len); b++) begin
      checkOutput($sformatf("%s b%0d rvalid", v.name, b), 64'(rvalid_o), 64'd1);
      checkOutput($sformatf("%s b%0d rdata", v.name, b), 64'(rdata_o), 64'(v.exp_data[b]));
      checkOutput($sformatf("%s b%0d rresp", v.name, b), 64'(rresp_o), 64'(v.exp_resp[b]));
      checkOutput($sformatf("%s b%0d rlast", v.name, b), 64'(rlast_o), 64'(b == int'(v.len)));
      checkOutput($sformatf("%s b%0d rid", v.name, b), 64'(rid_o), 64'(v.id));
      @(negedge clk_i);
    end
    rready_i = 1'b0;
    checkOutput({v.name, " end rvalid"}, 64'(rvalid_o), 64'd0);
    checkOutput({v.name, " end arready"}, 64'(arready_o), 64'd1);
  endtask

  // Random burst with random rready, checked against the model beat by beat.
  task automatic randomBurst(input logic [31:0] addr, input int len, input int size, input int burst, input logic [3:0] id);
    int beats, cycles;
    logic stalled;
    logic [31:0] sd, ed;
    logic [1:0] sr, er;
    logic sl;
    issueAr(addr, 8'(len), 3'(size), 2'(burst), id, 1'b0, "rand");
    beats = 0; cycles = 0; stalled = 1'b0; sd = '0; sr = '0; sl = 1'b0;
    while (beats <= len && cycles < 400) begin
      if (stalled) begin
        checkOutput("rand hold rdata", 64'(rdata_o), 64'(sd));
        checkOutput("rand hold rresp", 64'(rresp_o), 64'(sr));
        checkOutput("rand hold rlast", 64'(rlast_o), 64'(sl));
      end
      rready_i = ($urandom_range(0, 2) != 0);
      if (rvalid_o && rready_i) begin
        model_beat(addr, len, size, burst, beats, ed, er);
        checkOutput($sformatf("rand a=%0h b%0d rdata", addr, beats), 64'(rdata_o), 64'(ed));
        checkOutput($sformatf("rand a=%0h b%0d rresp", addr, beats), 64'(rresp_o), 64'(er));
        checkOutput($sformatf("rand a=%0h b%0d rlast", addr, beats), 64'(rlast_o), 64'(beats == len));
        checkOutput("rand rid", 64'(rid_o), 64'(id));
        beats++;
      end
      stalled = rvalid_o && !rready_i;
      sd = rdata_o; sr = rresp_o; sl = rlast_o;
      @(negedge clk_i);
      cycles++;
    end
    rready_i = 1'b0;
    checkOutput("rand beat count", 64'(beats), 64'(len + 1));
    checkOutput("rand end rvalid", 64'(rvalid_o), 64'd0);
    checkOutput("rand end arready", 64'(arready_o), 64'd1);
  endtask

  initial begin
    logic [31:0] old_word, held_data;
    logic [1:0]  held_resp;
    logic        held_last;
    logic [31:0] addr;
    int len, size, burst, mode;

    // Reset state
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("reset arready", 64'(arready_o), 64'd0);
    checkOutput("reset rvalid", 64'(rvalid_o), 64'd0);
    checkOutput("reset rlast", 64'(rlast_o), 64'd0);
    checkOutput("reset rid", 64'(rid_o), 64'd0);
    checkOutput("reset rdata", 64'(rdata_o), 64'd0);
    checkOutput("reset rresp", 64'(rresp_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("arready after release", 64'(arready_o), 64'd1);

    for (int i = 0; i < MEM_DEPTH; i++) preload(i, pat(i));
    for (int i = 0; i < 4; i++) preload(4 + i, 32'hA000_0000 + 32'(i));

    setVec(0, "incr", 32'h10, 8'd3, 3'd2, 2'd1, 4'd5,
           32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 2'd0, 2'd0, 2'd0, 2'd0);
    setVec(1, "wrap", 32'h18, 8'd3, 3'd2, 2'd2, 4'd3,
           32'hA000_0002, 32'hA000_0003, 32'hA000_0000, 32'hA000_0001, 2'd0, 2'd0, 2'd0, 2'd0);
    setVec(2, "fixed", 32'h20, 8'd2, 3'd2, 2'd0, 4'd1,
           pat(8), pat(8), pat(8), 32'h0, 2'd0, 2'd0, 2'd0, 2'd0);
    setVec(3, "boundary", 32'h3FC, 8'd1, 3'd2, 2'd1, 4'd15,
           pat(255), 32'h0, 32'h0, 32'h0, 2'd0, 2'd3, 2'd0, 2'd0);
    setVec(4, "size8", 32'h40, 8'd1, 3'd3, 2'd1, 4'd4,
           32'h0, 32'h0, 32'h0, 32'h0, 2'd2, 2'd2, 2'd0, 2'd0);
    setVec(5, "rsvd_burst", 32'h40, 8'd0, 3'd2, 2'd3, 4'd6,
           32'h0, 32'h0, 32'h0, 32'h0, 2'd2, 2'd0, 2'd0, 2'd0);
    setVec(6, "wrap_len2", 32'h10, 8'd2, 3'd2, 2'd2, 4'd7,
           32'h0, 32'h0, 32'h0, 32'h0, 2'd2, 2'd2, 2'd2, 2'd0);
    setVec(7, "wrap_unaligned", 32'h12, 8'd1, 3'd2, 2'd2, 4'd8,
           32'h0, 32'h0, 32'h0, 32'h0, 2'd2, 2'd2, 2'd0, 2'd0);
    setVec(8, "incr_narrow", 32'h11, 8'd3, 3'd0, 2'd1, 4'd9,
           32'hA000_0000, 32'hA000_0000, 32'hA000_0000, 32'hA000_0001, 2'd0, 2'd0, 2'd0, 2'd0);

    foreach (vecs[k]) applyStimulus(vecs[k]);

    // Backpressure on the second beat of an INCR burst
    issueAr(32'h10, 8'd3, 3'd2, 2'd1, 4'd2, 1'b1, "bp");
    checkOutput("bp b0 rdata", 64'(rdata_o), 64'hA000_0000);
    @(negedge clk_i);
    rready_i = 1'b0;
    held_data = rdata_o; held_resp = rresp_o; held_last = rlast_o;
    checkOutput("bp b1 rdata", 64'(rdata_o), 64'hA000_0001);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      checkOutput($sformatf("bp stall%0d rvalid", c), 64'(rvalid_o), 64'd1);
      checkOutput($sformatf("bp stall%0d rdata", c), 64'(rdata_o), 64'(held_data));
      checkOutput($sformatf("bp stall%0d rresp", c), 64'(rresp_o), 64'(held_resp));
      checkOutput($sformatf("bp stall%0d rlast", c), 64'(rlast_o), 64'(held_last));
      checkOutput($sformatf("bp stall%0d arready", c), 64'(arready_o), 64'd0);
    end
    rready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("bp b2 rdata", 64'(rdata_o), 64'hA000_0002);
    checkOutput("bp b2 arready", 64'(arready_o), 64'd0);
    @(negedge clk_i);
    checkOutput("bp b3 rdata", 64'(rdata_o), 64'hA000_0003);
    checkOutput("bp b3 rlast", 64'(rlast_o), 64'd1);
    @(negedge clk_i);
    rready_i = 1'b0;
    checkOutput("bp end arready", 64'(arready_o), 64'd1);
    checkOutput("bp end rvalid", 64'(rvalid_o), 64'd0);

    // Preload write at the same edge as the beat read returns the old word
    old_word = mem_model[8];
    mem_we_i = 1'b1; mem_waddr_i = 8'd8; mem_wdata_i = 32'hFEED_0008;
    issueAr(32'h20, 8'd1, 3'd2, 2'd0, 4'd11, 1'b0, "wr_collide");
    mem_we_i = 1'b0;
    mem_model[8] = 32'hFEED_0008;
    checkOutput("wr_collide b0 old data", 64'(rdata_o), 64'(old_word));
    rready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("wr_collide b1 new data", 64'(rdata_o), 64'hFEED_0008);
    checkOutput("wr_collide b1 rlast", 64'(rlast_o), 64'd1);
    @(negedge clk_i);
    rready_i = 1'b0;
    checkOutput("wr_collide end rvalid", 64'(rvalid_o), 64'd0);

    // Reset in the middle of a burst
    issueAr(32'h10, 8'd3, 3'd2, 2'd1, 4'd7, 1'b1, "rst_mid");
    @(negedge clk_i);
    rst_ni = 1'b0; rready_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rst_mid rvalid", 64'(rvalid_o), 64'd0);
    checkOutput("rst_mid arready", 64'(arready_o), 64'd0);
    checkOutput("rst_mid rlast", 64'(rlast_o), 64'd0);
    checkOutput("rst_mid rid", 64'(rid_o), 64'd0);
    checkOutput("rst_mid rdata", 64'(rdata_o), 64'd0);
    checkOutput("rst_mid rresp", 64'(rresp_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("rst_mid arready after release", 64'(arready_o), 64'd1);
    checkOutput("rst_mid no stray beat", 64'(rvalid_o), 64'd0);
    applyStimulus(vecs[0]);

    // Randomized bursts against the model, with occasional preload traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) preload($urandom_range(0, MEM_DEPTH - 1), $urandom);
      mode  = $urandom_range(0, 9);
      burst = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      size  = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
      if (burst == 2 && $urandom_range(0, 4) != 0) begin
        case ($urandom_range(0, 3))
          0: len = 1;
          1: len = 3;
          2: len = 7;
          default: len = 15;
        endcase
      end else begin
        len = $urandom_range(0, 7);
      end
      if (mode < 6)      addr = 32'($urandom_range(0, 1023));
      else if (mode < 8) addr = 32'h3C0 + 32'($urandom_range(0, 127));
      else               addr = 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
      if (burst == 2 && $urandom_range(0, 3) != 0) addr = addr - 32'(addr % (32'd1 << size));
      randomBurst(addr, len, size, burst, 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/axi_rd_responder.md
Name: axi_rd_responder

Overview:
- AXI4 read-channel subordinate (responder) for the verification environment. It accepts AR requests, walks the burst addresses (FIXED/INCR/WRAP), and returns R beats from an internal word memory with per-beat RRESP.
- Serves as the end-point model behind the crossbar's manager ports in the TB. It is the responder counterpart to the initiator-side AXI types and encodings.
- A preload port lets the bench fill the memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width in bits; power of two, at least 8.
- ID_W, 4, AXI ID width.
- MEM_DEPTH, 256, memory depth in DATA_W words.
- BASE_ADDR, 0, byte address of word 0.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock; synchronous, active-low.
- arvalid_i  in  1  AR valid.
- arready_o  out  1  AR ready.
- arid_i  in  ID_W  AR ID.
- araddr_i  in  ADDR_W  start byte address.
- arlen_i  in  8  beats minus 1.
- arsize_i  in  3  bytes per beat, axi_burst_size.
- arburst_i  in  2  burst type, axi_burst_type.
- rvalid_o  out  1  R valid.
- rready_i  in  1  R ready.
- rid_o  out  ID_W  echoed ARID.
- rdata_o  out  DATA_W  read data.
- rresp_o  out  2  axi_response.
- rlast_o  out  1  last beat.
- mem_we_i  in  1  preload write enable.
- mem_waddr_i  in  $clog2(MEM_DEPTH)  preload word index.
- mem_wdata_i  in  DATA_W  preload data.

Behaviour:
- Reset (rst_ni low at a clk_i edge): state=IDLE; arready_o=0; rvalid_o=0; rlast_o=0; rid_o=0; rdata_o=0; rresp_o=OKAY. Memory contents are not reset.
- Reset mid-burst: the burst is aborted, no further beats are sent, and outputs take their reset values on the next edge.
- All outputs are registered.
- FSM IDLE:
  - arready_o=1 from the first edge after reset release.
  - On arvalid_i&&arready_o: latch id/addr/len/size/burst, compute beat 0, load the R registers, set rvalid_o=1, drop arready_o, go to BURST.
  - Latency: handshake at edge N gives rvalid_o=1 after edge N.
- FSM BURST:
  - R outputs hold stable while rvalid_o&&!rready_i.
  - On rvalid_i&&rready_i handshake with beat count < len: advance the address and load the next beat in the same edge. There are no bubbles under continuous rready_i.
  - On handshake with rlast_o=1: rvalid_o=0, arready_o=1, go to IDLE. There is one idle cycle between bursts.
- Beat count: 9-bit counter 0..arlen_i; rlast_o=1 exactly on beat arlen_i; arlen_i=0 gives a single beat with rlast_o=1.
- Address generation, with bytes=1<<arsize and total=bytes*(arlen+1):
  - FIXED: every beat uses the start address.
  - INCR: beat0=start; next = (addr & ~(bytes-1)) + bytes. Unaligned start is allowed. No 4KB check is made; the address wraps modulo 2^ADDR_W.
  - WRAP: lower = start & ~(total-1); next = addr+bytes; if next == lower+total, then next = lower.
- Data: word index = (addr-BASE_ADDR) >> $clog2(DATA_W/8). The full word is returned with no lane shifting for narrow sizes. The memory is read at the edge the beat is loaded.
- Preload write and read of the same word at the same edge returns the old data; the write is visible from the next edge.
- Burst-level errors, decided at AR handshake, make every beat SLVERR with rdata_o=0:
  - arburst=2'b11.
  - bytes > DATA_W/8.
  - WRAP with arlen not in {1,3,7,15}.
  - WRAP with an unaligned start.
- Beat-level errors: if the burst is legal but a beat address is outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*DATA_W/8), that beat is DECERR with rdata_o=0; other beats are OKAY.
- The full arlen+1 beats are always sent, errors included.
- EXOKAY is never generated.

Decomposition:
- Shared package: reuse axi_burst_size, axi_burst_type and axi_response from the shared AXI types package. Add rd_resp_state_e {IDLE, BURST} there.
- Sub-module axi_burst_addr_gen: combinational next-address plus burst-legality check (inputs addr/len/size/burst). It is reused later by the write responder.

Test Plan (defaults; DATA_W=32, range 0x000-0x3FF):
- INCR: mem[4..7]=A0..A3; AR id=5, addr=0x10, len=3, size=4B, rready_i=1 -> 4 consecutive beats A0..A3, rid_o=5, OKAY, rlast_o only on beat 4, first rvalid_o 1 cycle after AR handshake.
- WRAP: AR addr=0x18, len=3, size=4B -> words 6,7,4,5 (addresses 0x18,0x1C,0x10,0x14), all OKAY. FIXED: addr=0x20, len=2 -> mem[8] three times.
- Boundary: INCR addr=0x3FC, len=1 -> beat0 mem[255] OKAY; beat1 (0x400) DECERR, rdata_o=0, rlast_o=1.
- Illegal bursts, each -> len+1 beats SLVERR, rdata_o=0:
  - arsize=3 (8B), len=1.
  - arburst=2'b11, len=0.
  - WRAP len=2.
- Backpressure: rready_i low 3 cycles at beat 2 of an INCR len=3 burst -> rdata_o/rlast_o/rresp_o stable; arready_o=0 throughout; arready_o=1 one cycle after the last handshake.
- Reset mid-burst: rst_ni low during beat 1 -> rvalid_o=0 after the edge; arready_o=1 one edge after release; memory retained.
